fetch_stage: RTL and testbench

Instruction-fetch stage. It sits directly upstream of the instruction memory: it owns the PC register, drives the memory's read address, and captures the returned word into the IF/ID pipeline register for the decoder. It handles stalls, branch/jump redirects (flush) and misaligned redirect targets, and keeps a fetch counter for debug.

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetch_stage_pc_next_mux.sv | 29 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage and the instruction memory it feeds.
// Address/width defaults must stay in step with the memory macro.
package rv_pkg;

  localparam int DEFAULT_INS_ADDRESS = 9;
  localparam int DEFAULT_INS_W       = 32;

  // addi x0, x0, 0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Next-PC selection: redirect target (forced word-aligned), hold, or sequential +4.
// Also flags redirect targets whose low two bits were not zero.
module pc_next_mux
  import rv_pkg::*;
#(
  parameter int INS_ADDRESS = DEFAULT_INS_ADDRESS
) (
  input  fetch_state_t            state_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [INS_ADDRESS-1:0]  target_i,
  input  logic [INS_ADDRESS-1:0]  pc_i,
  output logic [INS_ADDRESS-1:0]  pc_d_o,
  output logic                    misalign_o
);

  // Flush outranks stall; BOOT only advances when redirected.
  always_comb begin
    pc_d_o     = pc_i;
    misalign_o = 1'b0;
    if (flush_i) begin
      pc_d_o     = {target_i[INS_ADDRESS-1:2], 2'b00};
      misalign_o = |target_i[1:0];
    end else if (state_i == FETCH && !stall_i) begin
      pc_d_o = pc_i + INS_ADDRESS'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// captures its word into the IF/ID register, handling stall, flush and a debug count.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int INS_ADDRESS = DEFAULT_INS_ADDRESS,
  parameter int INS_W       = DEFAULT_INS_W,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [INS_ADDRESS-1:0] target_i,
  output logic [INS_ADDRESS-1:0] imem_ra_o,
  input  logic [INS_W-1:0]       imem_rd_i,
  output logic [INS_ADDRESS-1:0] pc_o,
  output logic [INS_W-1:0]       instr_o,
  output logic                   valid_o,
  output logic                   misalign_o,
  output logic [CNT_W-1:0]       fetch_count_o
);

  fetch_state_t            state_q, state_d;
  logic [INS_ADDRESS-1:0]  pc_q, pc_d;
  logic [INS_ADDRESS-1:0]  if_pc_q, if_pc_d;
  logic [INS_W-1:0]        instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    misalign_q, misalign_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    misalign_hit;

  pc_next_mux #(
    .INS_ADDRESS (INS_ADDRESS)
  ) u_pc_next_mux (
    .state_i    (state_q),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .target_i   (target_i),
    .pc_i       (pc_q),
    .pc_d_o     (pc_d),
    .misalign_o (misalign_hit)
  );

  // BOOT is a single settle cycle; IF/ID is only touched once in FETCH.
  always_comb begin
    state_d    = state_q;
    if_pc_d    = if_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    count_d    = count_q;
    misalign_d = misalign_q | misalign_hit;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (flush_i) begin
          if_pc_d = '0;
          instr_d = INS_W'(NOP_INSTR);
          valid_d = 1'b0;
        end else if (!stall_i) begin
          if_pc_d = pc_q;
          instr_d = imem_rd_i;
          valid_d = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      if_pc_q    <= '0;
      instr_q    <= INS_W'(NOP_INSTR);
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_ra_o     = pc_q;
  assign pc_o          = if_pc_q;
  assign instr_o       = instr_q;
  assign valid_o       = valid_q;
  assign misalign_o    = misalign_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table walks boot, stall, flush,
// misaligned redirect and PC wrap; hand-written sequences cover async reset.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [8:0]  target;
  logic [8:0]  imem_ra;
  logic [31:0] imem_rd;
  logic [8:0]  pc;
  logic [31:0] instr;
  logic        valid;
  logic        misalign;
  logic [15:0] fetch_count;

  logic [31:0] mem [128];

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [8:0]  target;
    logic        exp_valid;
    logic [8:0]  exp_pc;
    logic [31:0] exp_instr;
    logic [8:0]  exp_ra;
    logic [15:0] exp_count;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [15];

  fetch_stage #(
    .INS_ADDRESS (9),
    .INS_W       (32),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .flush_i       (flush),
    .target_i      (target),
    .imem_ra_o     (imem_ra),
    .imem_rd_i     (imem_rd),
    .pc_o          (pc),
    .instr_o       (instr),
    .valid_o       (valid),
    .misalign_o    (misalign),
    .fetch_count_o (fetch_count)
  );

  assign imem_rd = mem[imem_ra[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic f, input logic [8:0] t);
    stall  = s;
    flush  = f;
    target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_valid, input logic [8:0] e_pc,
                             input logic [31:0] e_instr, input logic [8:0] e_ra,
                             input logic [15:0] e_count, input logic e_mis);
    checks++;
    if (valid !== e_valid) begin
      errors++;
      $display("[TB] FAIL %s valid: got %0b want %0b", name, valid, e_valid);
    end
    checks++;
    if (pc !== e_pc) begin
      errors++;
      $display("[TB] FAIL %s pc_o: got %h want %h", name, pc, e_pc);
    end
    checks++;
    if (instr !== e_instr) begin
      errors++;
      $display("[TB] FAIL %s instr_o: got %h want %h", name, instr, e_instr);
    end
    checks++;
    if (imem_ra !== e_ra) begin
      errors++;
      $display("[TB] FAIL %s imem_ra_o: got %h want %h", name, imem_ra, e_ra);
    end
    checks++;
    if (fetch_count !== e_count) begin
      errors++;
      $display("[TB] FAIL %s fetch_count_o: got %0d want %0d", name, fetch_count, e_count);
    end
    checks++;
    if (misalign !== e_mis) begin
      errors++;
      $display("[TB] FAIL %s misalign_o: got %0b want %0b", name, misalign, e_mis);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    target = '0;

    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[0]  = 32'h00007033;
    mem[1]  = 32'h00100093;
    mem[2]  = 32'h00200113;
    mem[3]  = 32'h00308193;
    mem[8]  = 32'h00208433;

    //            name         stl  fl  target  valid pc_o    instr          ra      cnt  mis
    vecs[0]  = '{"boot",       0, 0, 9'h000, 0, 9'h000, NOP,          9'h000, 16'd0, 0};
    vecs[1]  = '{"fetch0",     0, 0, 9'h000, 1, 9'h000, 32'h00007033, 9'h004, 16'd1, 0};
    vecs[2]  = '{"fetch4",     0, 0, 9'h000, 1, 9'h004, 32'h00100093, 9'h008, 16'd2, 0};
    vecs[3]  = '{"fetch8",     0, 0, 9'h000, 1, 9'h008, 32'h00200113, 9'h00C, 16'd3, 0};
    vecs[4]  = '{"stall1",     1, 0, 9'h000, 1, 9'h008, 32'h00200113, 9'h00C, 16'd3, 0};
    vecs[5]  = '{"stall2",     1, 0, 9'h000, 1, 9'h008, 32'h00200113, 9'h00C, 16'd3, 0};
    vecs[6]  = '{"stall3",     1, 0, 9'h000, 1, 9'h008, 32'h00200113, 9'h00C, 16'd3, 0};
    vecs[7]  = '{"fetchC",     0, 0, 9'h000, 1, 9'h00C, 32'h00308193, 9'h010, 16'd4, 0};
    vecs[8]  = '{"flush20",    0, 1, 9'h020, 0, 9'h000, NOP,          9'h020, 16'd4, 0};
    vecs[9]  = '{"fetch20",    0, 0, 9'h000, 1, 9'h020, 32'h00208433, 9'h024, 16'd5, 0};
    vecs[10] = '{"flushstl22", 1, 1, 9'h022, 0, 9'h000, NOP,          9'h020, 16'd5, 1};
    vecs[11] = '{"flush40",    0, 1, 9'h040, 0, 9'h000, NOP,          9'h040, 16'd5, 1};
    vecs[12] = '{"flush1FC",   0, 1, 9'h1FC, 0, 9'h000, NOP,          9'h1FC, 16'd5, 1};
    vecs[13] = '{"fetch1FC",   0, 0, 9'h000, 1, 9'h1FC, 32'hC0DE007F, 9'h000, 16'd6, 1};
    vecs[14] = '{"wrap0",      0, 0, 9'h000, 1, 9'h000, 32'h00007033, 9'h004, 16'd7, 1};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 9'h000, NOP, 9'h000, 16'd0, 0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].target);
      checkOutput(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_instr,
                  vecs[i].exp_ra, vecs[i].exp_count, vecs[i].exp_mis);
    end

    // Asynchronous reset between edges while a valid instruction is held
    stall = 1'b0;
    flush = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 0, 9'h000, NOP, 9'h000, 16'd0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Stall during BOOT must not extend it
    applyStimulus(1'b1, 1'b0, 9'h000);
    checkOutput("reboot", 0, 9'h000, NOP, 9'h000, 16'd0, 0);
    applyStimulus(1'b0, 1'b0, 9'h000);
    checkOutput("refetch0", 1, 9'h000, 32'h00007033, 9'h004, 16'd1, 0);
    applyStimulus(1'b0, 1'b0, 9'h000);
    checkOutput("refetch4", 1, 9'h004, 32'h00100093, 9'h008, 16'd2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
